// File: rtl/rst_sequencer_pkg.sv
// Shared types and default timing constants for the rover reset sequencer.
// The state encodings are visible on the debug port, so they are fixed here.
package rover_rst_pkg;

    typedef enum logic [2:0] {
        ST_HOLD      = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_RELEASE   = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } rst_state_e;

    localparam int OSC_HZ           = 12_000_000;
    localparam int DEF_HOLD_CYCLES  = OSC_HZ / 1_000_000;  // 1 us of oscillator cycles
    localparam int DEF_LOCK_TIMEOUT = OSC_HZ / 10_000;     // 100 us of oscillator cycles
    localparam int DEF_NUM_DOMAINS  = 4;
    localparam int DEF_LOCK_STABLE  = 8;
    localparam int DEF_STAGE_GAP    = 4;
    localparam int DEF_SW_PULSE     = 16;

    // A counter that stops at its terminal value only needs to represent max_val.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val) + 1;
    endfunction

endpackage

// File: rtl/rst_sequencer_if.sv
// Lock/software-request inputs and reset/status outputs of the sequencer.
// The sequencer takes the slave side; the board top (or a bench) takes the master side.
interface rst_sequencer_if #(
    parameter int NUM_DOMAINS = 4
);
    logic                   clkLocked;
    logic [NUM_DOMAINS-1:0] swRstReq;
    logic [NUM_DOMAINS-1:0] rstOut;
    logic                   allReleased;
    logic                   lockFault;
    logic [2:0]             seqState;

    modport master (
        output clkLocked, swRstReq,
        input  rstOut, allReleased, lockFault, seqState
    );

    modport slave (
        input  clkLocked, swRstReq,
        output rstOut, allReleased, lockFault, seqState
    );
endinterface

// File: rtl/rst_sequencer_sync_2ff.sv
// Generic two-flop synchroniser for slow level signals crossing into clk.
// Both stages clear to 0 under rst so downstream logic sees "not asserted".
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);
    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    // NOTE: non-blocking assignments let both stages sample before either updates,
    // which is what makes this a two-stage shift rather than a single wire.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= '0;
            r_sync <= '0;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule

// File: rtl/rst_sequencer.sv
// Power-on / run-time reset sequencer: hold, wait for stable clock lock, release
// domains in staggered order, re-sequence on lock loss, per-domain software pulses.
module rst_sequencer
    import rover_rst_pkg::*;
#(
    parameter int NUM_DOMAINS  = DEF_NUM_DOMAINS,
    parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES,
    parameter int LOCK_STABLE  = DEF_LOCK_STABLE,
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter int STAGE_GAP    = DEF_STAGE_GAP,
    parameter int SW_PULSE     = DEF_SW_PULSE
) (
    input logic           OSCCLK,
    input logic           EXTRST,
    rst_sequencer_if.slave bus
);
    localparam int CNT_MAX = (HOLD_CYCLES > LOCK_STABLE) ? HOLD_CYCLES - 1 : LOCK_STABLE - 1;
    localparam int CNT_W   = cnt_width(CNT_MAX);
    localparam int TMO_W   = cnt_width(LOCK_TIMEOUT - 1);
    localparam int GAP_W   = cnt_width(STAGE_GAP - 1);
    localparam int STG_W   = cnt_width(NUM_DOMAINS - 1);
    localparam int PUL_W   = cnt_width(SW_PULSE);

    rst_state_e             r_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [TMO_W-1:0]       r_tmo;
    logic [GAP_W-1:0]       r_gap;
    logic [STG_W-1:0]       r_stage;
    logic [PUL_W-1:0]       r_pulse [NUM_DOMAINS];
    logic [NUM_DOMAINS-1:0] r_sw_prev;
    logic [NUM_DOMAINS-1:0] r_rst_out;
    logic                   r_all_rel;
    logic                   r_lock_fault;

    rst_state_e             w_state_nx;
    logic [CNT_W-1:0]       w_cnt_nx;
    logic [TMO_W-1:0]       w_tmo_nx;
    logic [GAP_W-1:0]       w_gap_nx;
    logic [STG_W-1:0]       w_stage_nx;
    logic [PUL_W-1:0]       w_pulse_nx [NUM_DOMAINS];
    logic [NUM_DOMAINS-1:0] w_rst_out_nx;
    logic                   w_lock_fault_nx;
    logic                   w_all_rel_nx;
    logic                   w_lock_s;
    logic [NUM_DOMAINS-1:0] w_sw_rise;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk (OSCCLK),
        .rst (EXTRST),
        .i_d (bus.clkLocked),
        .o_q (w_lock_s)
    );

    assign w_sw_rise = bus.swRstReq & ~r_sw_prev;

    // NOTE: every output of this block gets a default first so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    always_comb begin
        w_state_nx      = r_state;
        w_cnt_nx        = r_cnt;
        w_tmo_nx        = r_tmo;
        w_gap_nx        = r_gap;
        w_stage_nx      = r_stage;
        w_pulse_nx      = r_pulse;
        w_rst_out_nx    = r_rst_out;
        w_lock_fault_nx = r_lock_fault;

        case (r_state)
            ST_HOLD: begin
                w_rst_out_nx = '1;
                if (r_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                    w_state_nx = ST_WAIT_LOCK;
                    w_cnt_nx   = '0;
                    w_tmo_nx   = '0;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                // Stability is tested first so a lock completing on the timeout cycle still releases.
                if (w_lock_s && (r_cnt == CNT_W'(LOCK_STABLE - 1))) begin
                    w_state_nx = ST_RELEASE;
                    w_cnt_nx   = '0;
                    w_gap_nx   = '0;
                    w_stage_nx = '0;
                end else if (r_tmo == TMO_W'(LOCK_TIMEOUT - 1)) begin
                    w_state_nx      = ST_FAULT;
                    w_lock_fault_nx = 1'b1;
                end else begin
                    w_tmo_nx = r_tmo + 1'b1;
                    w_cnt_nx = w_lock_s ? r_cnt + 1'b1 : '0;
                end
            end
            ST_RELEASE: begin
                if (r_gap == '0) begin
                    for (int k = 0; k < NUM_DOMAINS; k++) begin
                        if (r_stage == STG_W'(k)) w_rst_out_nx[k] = 1'b0;
                    end
                    if (r_stage == STG_W'(NUM_DOMAINS - 1)) begin
                        w_state_nx = ST_RUN;
                    end else begin
                        w_stage_nx = r_stage + 1'b1;
                        w_gap_nx   = GAP_W'(STAGE_GAP - 1);
                    end
                end else begin
                    w_gap_nx = r_gap - 1'b1;
                end
            end
            ST_RUN: begin
                for (int i = 0; i < NUM_DOMAINS; i++) begin
                    if (w_sw_rise[i]) begin
                        w_pulse_nx[i] = PUL_W'(SW_PULSE);
                    end else if (r_pulse[i] != '0) begin
                        w_pulse_nx[i] = r_pulse[i] - 1'b1;
                    end
                    w_rst_out_nx[i] = (w_pulse_nx[i] != '0);
                end
            end
            ST_FAULT: begin
                w_rst_out_nx    = '1;
                w_lock_fault_nx = 1'b1;
            end
            default: begin
                w_state_nx   = ST_HOLD;
                w_cnt_nx     = '0;
                w_rst_out_nx = '1;
            end
        endcase

        // Lock loss outranks any software pulse and restarts the whole sequence.
        if (((r_state == ST_RELEASE) || (r_state == ST_RUN)) && !w_lock_s) begin
            w_state_nx   = ST_HOLD;
            w_cnt_nx     = '0;
            w_tmo_nx     = '0;
            w_gap_nx     = '0;
            w_stage_nx   = '0;
            w_pulse_nx   = '{default: '0};
            w_rst_out_nx = '1;
        end

        w_all_rel_nx = (w_state_nx == ST_RUN) && (w_rst_out_nx == '0);
    end

    always_ff @(posedge OSCCLK) begin
        if (EXTRST) begin
            r_state      <= ST_HOLD;
            r_cnt        <= '0;
            r_tmo        <= '0;
            r_gap        <= '0;
            r_stage      <= '0;
            r_pulse      <= '{default: '0};
            r_sw_prev    <= '0;
            r_rst_out    <= '1;
            r_all_rel    <= 1'b0;
            r_lock_fault <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_cnt        <= w_cnt_nx;
            r_tmo        <= w_tmo_nx;
            r_gap        <= w_gap_nx;
            r_stage      <= w_stage_nx;
            r_pulse      <= w_pulse_nx;
            r_sw_prev    <= bus.swRstReq;
            r_rst_out    <= w_rst_out_nx;
            r_all_rel    <= w_all_rel_nx;
            r_lock_fault <= w_lock_fault_nx;
        end
    end

    assign bus.rstOut      = r_rst_out;
    assign bus.allReleased = r_all_rel;
    assign bus.lockFault   = r_lock_fault;
    assign bus.seqState    = r_state;
endmodule
